// File: rtl/dm_arb_pkg.sv
// ---------------------------------------------------------------------------
// dm_arb_pkg
// Shared types and constants for the data-memory arbiter slice.
//   state_e     : arbiter sequencer states (IDLE -> ACCESS -> ACK -> IDLE)
//   PORT0/PORT1 : requester ids as carried on grant_id / last_grant
//   ADDR_W_DEF  : default address width (256-entry data memory)
//   DATA_W_DEF  : default data width
// ---------------------------------------------------------------------------
package dm_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_e;

endpackage

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Combinational two-way picker for the data-memory arbiter.
//   req0, req1  : in  - pending requests from port 0 / port 1
//   last_grant  : in  - id of the most recently granted port
//   fixed_prio  : in  - 1 = port 0 wins ties, 0 = alternate on ties
//   gnt_valid   : out - at least one request is pending
//   gnt_id      : out - id of the port that would be granted
// ---------------------------------------------------------------------------
module rr_pick2
    import dm_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    input  logic fixed_prio,
    output logic gnt_valid,
    output logic gnt_id
);

    // On a tie the round-robin choice is simply the port that was not served
    // last; a lone request always wins regardless of history.
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_id    = PORT0;
        if (req0 && req1) begin
            gnt_id = fixed_prio ? PORT0 : ~last_grant;
        end else if (req1) begin
            gnt_id = PORT1;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// ---------------------------------------------------------------------------
// dm_arbiter
// Shares a 256x8 data memory between two requesters over a req/ack
// handshake. Each access is one sequenced DM cycle; read data is registered
// back to the winning requester.
//   CLK, RST_N            : clock (rising edge), async active-low reset
//   req/we/addr/wdata 0,1 : request bundle per port, held until ack
//   ack0, ack1            : one-cycle completion pulse per port
//   rdata0, rdata1        : last read data per port, held between reads
//   dm_wrt_en/address/
//   dm_wrt_data           : registered drive to the DM pins
//   dm_rd_data            : combinational read data from DM
//   busy                  : high while an access is in flight (ACCESS/ACK)
//   grant_id              : port currently or most recently served
// ---------------------------------------------------------------------------
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIXED_PRIO = 0
)
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              dm_wrt_en,
    output logic [ADDR_W-1:0] dm_address,
    output logic [DATA_W-1:0] dm_wrt_data,
    input  logic [DATA_W-1:0] dm_rd_data,
    output logic              busy,
    output logic              grant_id
);

    state_e              state_q;
    logic                last_grant_q;
    logic                we_q;
    logic                grant_id_q;
    logic                busy_q;
    logic                ack0_q;
    logic                ack1_q;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;
    logic                dm_wrt_en_q;
    logic [ADDR_W-1:0]   dm_address_q;
    logic [DATA_W-1:0]   dm_wrt_data_q;

    logic                gnt_valid;
    logic                gnt_id;
    logic                sel_we_d;
    logic [ADDR_W-1:0]   sel_addr_d;
    logic [DATA_W-1:0]   sel_wdata_d;

    rr_pick2 u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_q),
        .fixed_prio (FIXED_PRIO != 0),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    // Request bundle of whichever port the picker would grant this cycle.
    always_comb begin
        sel_we_d    = we0;
        sel_addr_d  = addr0;
        sel_wdata_d = wdata0;
        if (gnt_id == PORT1) begin
            sel_we_d    = we1;
            sel_addr_d  = addr1;
            sel_wdata_d = wdata1;
        end
    end

    // Sequencer. dm_address/dm_wrt_data double as the latched request and
    // keep their value outside ACCESS; dm_wrt_en is only ever set on the
    // IDLE->ACCESS edge and cleared on the next, so a write commits exactly
    // at the ACCESS->ACK edge. The async reset clears dm_wrt_en at once, so
    // an interrupted write never reaches the memory.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            last_grant_q  <= PORT1;
            we_q          <= 1'b0;
            grant_id_q    <= PORT0;
            busy_q        <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            dm_wrt_en_q   <= 1'b0;
            dm_address_q  <= '0;
            dm_wrt_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                    if (gnt_valid) begin
                        state_q       <= ACCESS;
                        busy_q        <= 1'b1;
                        grant_id_q    <= gnt_id;
                        last_grant_q  <= gnt_id;
                        we_q          <= sel_we_d;
                        dm_wrt_en_q   <= sel_we_d;
                        dm_address_q  <= sel_addr_d;
                        dm_wrt_data_q <= sel_wdata_d;
                    end
                end
                ACCESS: begin
                    state_q     <= ACK;
                    dm_wrt_en_q <= 1'b0;
                    if (grant_id_q == PORT1) begin
                        ack1_q <= 1'b1;
                        if (!we_q) begin
                            rdata1_q <= dm_rd_data;
                        end
                    end else begin
                        ack0_q <= 1'b1;
                        if (!we_q) begin
                            rdata0_q <= dm_rd_data;
                        end
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    ack0_q      <= 1'b0;
                    ack1_q      <= 1'b0;
                    dm_wrt_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign dm_wrt_en   = dm_wrt_en_q;
    assign dm_address  = dm_address_q;
    assign dm_wrt_data = dm_wrt_data_q;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dm_arbiter
// Two arbiters side by side, each with its own behavioural 256x8 memory:
// instance 0 is round-robin, instance 1 is fixed priority. Directed
// scenarios are followed by a randomized run against a transaction-level
// reference model.
// ---------------------------------------------------------------------------
module tb_dm_arbiter;

    logic       CLK;
    logic       RST_N;
    logic       preloadReq;

    logic [1:0] req0, we0, req1, we1;
    logic [7:0] addr0 [2];
    logic [7:0] wdata0 [2];
    logic [7:0] addr1 [2];
    logic [7:0] wdata1 [2];

    logic [1:0] ack0, ack1, dmWrtEn, busy, grantId;
    logic [7:0] rdata0 [2];
    logic [7:0] rdata1 [2];
    logic [7:0] dmAddress [2];
    logic [7:0] dmWrtData [2];
    logic [7:0] dmRdData [2];

    logic [7:0] dmMem [2][256];

    int vectors;
    int miscompares;

    dm_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0)) dutRr (
        .CLK(CLK), .RST_N(RST_N),
        .req0(req0[0]), .we0(we0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]),
        .ack0(ack0[0]), .rdata0(rdata0[0]),
        .req1(req1[0]), .we1(we1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]),
        .ack1(ack1[0]), .rdata1(rdata1[0]),
        .dm_wrt_en(dmWrtEn[0]), .dm_address(dmAddress[0]),
        .dm_wrt_data(dmWrtData[0]), .dm_rd_data(dmRdData[0]),
        .busy(busy[0]), .grant_id(grantId[0])
    );

    dm_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1)) dutFix (
        .CLK(CLK), .RST_N(RST_N),
        .req0(req0[1]), .we0(we0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]),
        .ack0(ack0[1]), .rdata0(rdata0[1]),
        .req1(req1[1]), .we1(we1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]),
        .ack1(ack1[1]), .rdata1(rdata1[1]),
        .dm_wrt_en(dmWrtEn[1]), .dm_address(dmAddress[1]),
        .dm_wrt_data(dmWrtData[1]), .dm_rd_data(dmRdData[1]),
        .busy(busy[1]), .grant_id(grantId[1])
    );

    // Free-running clock, 10 time units per period.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural data memory per instance: preload mem[n]=n on request,
    // otherwise commit a write on the clock edge while wrt_en is high.
    always @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (preloadReq) begin
                for (int n = 0; n < 256; n++) begin
                    dmMem[i][n] <= 8'(n);
                end
            end else if (dmWrtEn[i]) begin
                dmMem[i][dmAddress[i]] <= dmWrtData[i];
            end
        end
    end

    // Combinational read port; the memory returns 0 while being written.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            dmRdData[i] = dmWrtEn[i] ? 8'h00 : dmMem[i][dmAddress[i]];
        end
    end

    // One clock: pass the active edge, then settle on the falling edge.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Drop every request input to a quiet value.
    task automatic idleInputs();
        for (int i = 0; i < 2; i++) begin
            req0[i] = 1'b0; we0[i] = 1'b0; addr0[i] = 8'h00; wdata0[i] = 8'h00;
            req1[i] = 1'b0; we1[i] = 1'b0; addr1[i] = 8'h00; wdata1[i] = 8'h00;
        end
    endtask

    // Reset both arbiters and reload both memories with mem[n]=n.
    task automatic applyReset();
        idleInputs();
        RST_N      = 1'b0;
        preloadReq = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        preloadReq = 1'b0;
        RST_N      = 1'b1;
    endtask

    task automatic test_reset();
        idleInputs();
        preloadReq = 1'b0;
        RST_N      = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({ack0[i], ack1[i], busy[i], grantId[i], dmWrtEn[i]} !== 5'b00000) begin
                miscompares++;
                $display("[TB] FAIL reset_ctrl inst%0d: got %b expected 00000", i,
                         {ack0[i], ack1[i], busy[i], grantId[i], dmWrtEn[i]});
            end
            vectors++;
            if ({dmAddress[i], dmWrtData[i], rdata0[i], rdata1[i]} !== 32'h0) begin
                miscompares++;
                $display("[TB] FAIL reset_data inst%0d: got %h expected 00000000", i,
                         {dmAddress[i], dmWrtData[i], rdata0[i], rdata1[i]});
            end
        end
        applyReset();
    endtask

    task automatic test_single_read();
        req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 8'd23;
        tick();
        vectors++;
        if ({busy[0], ack0[0], dmWrtEn[0]} !== 3'b100 || dmAddress[0] !== 8'd23) begin
            miscompares++;
            $display("[TB] FAIL single_access: got busy/ack/we=%b addr=%0d expected 100 addr=23",
                     {busy[0], ack0[0], dmWrtEn[0]}, dmAddress[0]);
        end
        tick();
        vectors++;
        if ({ack0[0], ack1[0], dmWrtEn[0]} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL single_ack: got %b expected 100", {ack0[0], ack1[0], dmWrtEn[0]});
        end
        vectors++;
        if (rdata0[0] !== 8'd23) begin
            miscompares++;
            $display("[TB] FAIL single_rdata: got %0d expected 23", rdata0[0]);
        end
        req0[0] = 1'b0;
        tick();
        vectors++;
        if ({ack0[0], busy[0], dmWrtEn[0]} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL single_done: got %b expected 000", {ack0[0], busy[0], dmWrtEn[0]});
        end
    endtask

    task automatic test_write_read();
        req1[0] = 1'b1; we1[0] = 1'b1; addr1[0] = 8'd200; wdata1[0] = 8'hA5;
        tick();
        vectors++;
        if ({dmWrtEn[0], grantId[0], dmAddress[0], dmWrtData[0]} !== {1'b1, 1'b1, 8'd200, 8'hA5}) begin
            miscompares++;
            $display("[TB] FAIL wr_access: got we=%b gid=%b addr=%0d data=%h expected 1 1 200 a5",
                     dmWrtEn[0], grantId[0], dmAddress[0], dmWrtData[0]);
        end
        tick();
        vectors++;
        if ({ack1[0], ack0[0], dmWrtEn[0]} !== 3'b100 || rdata1[0] !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL wr_ack: got ack1/ack0/we=%b rdata1=%h expected 100 00",
                     {ack1[0], ack0[0], dmWrtEn[0]}, rdata1[0]);
        end
        we1[0] = 1'b0;
        tick();
        vectors++;
        if ({ack1[0], busy[0], dmWrtEn[0]} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL wr_idle: got %b expected 000", {ack1[0], busy[0], dmWrtEn[0]});
        end
        tick();
        vectors++;
        if ({busy[0], grantId[0], dmWrtEn[0]} !== 3'b110) begin
            miscompares++;
            $display("[TB] FAIL rd_access: got %b expected 110", {busy[0], grantId[0], dmWrtEn[0]});
        end
        tick();
        vectors++;
        if ({ack1[0], rdata1[0], rdata0[0]} !== {1'b1, 8'hA5, 8'd23}) begin
            miscompares++;
            $display("[TB] FAIL rd_ack: got ack1=%b rdata1=%h rdata0=%0d expected 1 a5 23",
                     ack1[0], rdata1[0], rdata0[0]);
        end
        req1[0] = 1'b0;
        tick();
    endtask

    task automatic test_rr_contention();
        logic [1:0] expAck;
        applyReset();
        req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 8'd5;
        req1[0] = 1'b1; we1[0] = 1'b0; addr1[0] = 8'd7;
        for (int c = 1; c <= 12; c++) begin
            tick();
            expAck = 2'b00;
            if (c % 3 == 2) expAck = ((c / 3) % 2 == 0) ? 2'b10 : 2'b01;
            vectors++;
            if ({ack0[0], ack1[0]} !== expAck) begin
                miscompares++;
                $display("[TB] FAIL rr_ack cyc%0d: got %b expected %b", c, {ack0[0], ack1[0]}, expAck);
            end
        end
        vectors++;
        if ({rdata0[0], rdata1[0]} !== {8'd5, 8'd7}) begin
            miscompares++;
            $display("[TB] FAIL rr_rdata: got %0d/%0d expected 5/7", rdata0[0], rdata1[0]);
        end
        idleInputs();
        repeat (3) tick();
    endtask

    task automatic test_fixed_contention();
        logic [1:0] expAck;
        applyReset();
        req0[1] = 1'b1; we0[1] = 1'b0; addr0[1] = 8'd5;
        req1[1] = 1'b1; we1[1] = 1'b0; addr1[1] = 8'd7;
        for (int c = 1; c <= 14; c++) begin
            tick();
            expAck = 2'b00;
            if (c == 2 || c == 5 || c == 8 || c == 11) expAck = 2'b10;
            if (c == 14) expAck = 2'b01;
            vectors++;
            if ({ack0[1], ack1[1]} !== expAck) begin
                miscompares++;
                $display("[TB] FAIL fix_ack cyc%0d: got %b expected %b", c, {ack0[1], ack1[1]}, expAck);
            end
            if (c == 11) req0[1] = 1'b0;
        end
        vectors++;
        if ({rdata0[1], rdata1[1]} !== {8'd5, 8'd7}) begin
            miscompares++;
            $display("[TB] FAIL fix_rdata: got %0d/%0d expected 5/7", rdata0[1], rdata1[1]);
        end
        idleInputs();
        tick();
    endtask

    task automatic test_reset_mid_write();
        req0[0] = 1'b1; we0[0] = 1'b1; addr0[0] = 8'd10; wdata0[0] = 8'hFF;
        tick();
        vectors++;
        if (dmWrtEn[0] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rst_wr_access: got we=%b expected 1", dmWrtEn[0]);
        end
        #2 RST_N = 1'b0;
        #1;
        vectors++;
        if ({dmWrtEn[0], busy[0]} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL rst_async: got we/busy=%b expected 00", {dmWrtEn[0], busy[0]});
        end
        req0[0] = 1'b0;
        tick();
        vectors++;
        if ({ack0[0], ack1[0]} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL rst_noack: got %b expected 00", {ack0[0], ack1[0]});
        end
        RST_N   = 1'b1;
        req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 8'd10;
        tick();
        tick();
        vectors++;
        if ({ack0[0], rdata0[0]} !== {1'b1, 8'd10}) begin
            miscompares++;
            $display("[TB] FAIL rst_readback: got ack0=%b rdata0=%h expected 1 0a", ack0[0], rdata0[0]);
        end
        req0[0] = 1'b0;
        tick();
    endtask

    task automatic test_holdoff();
        req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 8'd3;
        tick();
        req1[0] = 1'b1; we1[0] = 1'b0; addr1[0] = 8'd40;
        tick();
        vectors++;
        if ({ack0[0], ack1[0], grantId[0]} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL hold_ack0: got %b expected 100", {ack0[0], ack1[0], grantId[0]});
        end
        req0[0] = 1'b0;
        tick();
        vectors++;
        if ({busy[0], ack1[0]} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL hold_idle: got %b expected 00", {busy[0], ack1[0]});
        end
        tick();
        vectors++;
        if ({busy[0], grantId[0], ack1[0]} !== 3'b110) begin
            miscompares++;
            $display("[TB] FAIL hold_grant: got %b expected 110", {busy[0], grantId[0], ack1[0]});
        end
        tick();
        vectors++;
        if ({ack1[0], rdata1[0], rdata0[0]} !== {1'b1, 8'd40, 8'd3}) begin
            miscompares++;
            $display("[TB] FAIL hold_ack1: got ack1=%b rdata1=%0d rdata0=%0d expected 1 40 3",
                     ack1[0], rdata1[0], rdata0[0]);
        end
        req1[0] = 1'b0;
        tick();
    endtask

    // Randomized traffic on both instances. The reference model works per
    // transaction: when the memory is free and someone asks, the rule picks a
    // winner; the access completes one cycle later (memory updated or read
    // data returned with ack), and the memory is free again three cycles after
    // the grant.
    task automatic test_random(input int nCycles);
        int         startCyc [2];
        logic       refLast [2];
        logic       txWin [2];
        logic       txWe [2];
        logic [7:0] txAddr [2];
        logic [7:0] txData [2];
        logic [7:0] refMem [2][256];
        logic [1:0] expAck0, expAck1, expBusy, expGid, expWe;
        logic [7:0] expAddr [2];
        logic [7:0] expData [2];
        logic [7:0] expRd0 [2];
        logic [7:0] expRd1 [2];
        int         age;
        logic       win;
        logic       granted;

        applyReset();
        expAck0 = 2'b00; expAck1 = 2'b00; expBusy = 2'b00; expGid = 2'b00; expWe = 2'b00;
        for (int i = 0; i < 2; i++) begin
            startCyc[i] = -100;
            refLast[i]  = 1'b1;
            txWin[i] = 1'b0; txWe[i] = 1'b0; txAddr[i] = 8'h00; txData[i] = 8'h00;
            expAddr[i] = 8'h00; expData[i] = 8'h00; expRd0[i] = 8'h00; expRd1[i] = 8'h00;
            for (int n = 0; n < 256; n++) refMem[i][n] = 8'(n);
        end

        for (int c = 1; c <= nCycles; c++) begin
            @(posedge CLK);
            for (int i = 0; i < 2; i++) begin
                age = c - startCyc[i];
                if (age == 1) begin
                    expWe[i] = 1'b0;
                    if (txWin[i]) expAck1[i] = 1'b1; else expAck0[i] = 1'b1;
                    if (txWe[i]) refMem[i][txAddr[i]] = txData[i];
                    else if (txWin[i]) expRd1[i] = refMem[i][txAddr[i]];
                    else expRd0[i] = refMem[i][txAddr[i]];
                end else if (age == 2) begin
                    expAck0[i] = 1'b0; expAck1[i] = 1'b0; expBusy[i] = 1'b0;
                end else if (age >= 3 && (req0[i] || req1[i])) begin
                    if (req0[i] && req1[i]) win = (i == 1) ? 1'b0 : !refLast[i];
                    else win = req1[i];
                    refLast[i]  = win;
                    startCyc[i] = c;
                    txWin[i]    = win;
                    txWe[i]     = win ? we1[i] : we0[i];
                    txAddr[i]   = win ? addr1[i] : addr0[i];
                    txData[i]   = win ? wdata1[i] : wdata0[i];
                    expBusy[i]  = 1'b1;
                    expGid[i]   = win;
                    expWe[i]    = txWe[i];
                    expAddr[i]  = txAddr[i];
                    expData[i]  = txData[i];
                end
            end

            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if ({ack0[i], ack1[i]} !== {expAck0[i], expAck1[i]}) begin
                    miscompares++;
                    $display("[TB] FAIL rand_ack inst%0d cyc%0d: got %b expected %b", i, c,
                             {ack0[i], ack1[i]}, {expAck0[i], expAck1[i]});
                end
                vectors++;
                if ({busy[i], grantId[i], dmWrtEn[i]} !== {expBusy[i], expGid[i], expWe[i]}) begin
                    miscompares++;
                    $display("[TB] FAIL rand_ctrl inst%0d cyc%0d: got %b expected %b", i, c,
                             {busy[i], grantId[i], dmWrtEn[i]}, {expBusy[i], expGid[i], expWe[i]});
                end
                vectors++;
                if ({dmAddress[i], dmWrtData[i]} !== {expAddr[i], expData[i]}) begin
                    miscompares++;
                    $display("[TB] FAIL rand_dmbus inst%0d cyc%0d: got %h expected %h", i, c,
                             {dmAddress[i], dmWrtData[i]}, {expAddr[i], expData[i]});
                end
                vectors++;
                if ({rdata0[i], rdata1[i]} !== {expRd0[i], expRd1[i]}) begin
                    miscompares++;
                    $display("[TB] FAIL rand_rdata inst%0d cyc%0d: got %h expected %h", i, c,
                             {rdata0[i], rdata1[i]}, {expRd0[i], expRd1[i]});
                end
            end

            // Requesters: hold a granted request until its ack, then either
            // drop it or issue a fresh one; waiting requests may be abandoned.
            for (int i = 0; i < 2; i++) begin
                age = c - startCyc[i];
                granted = (age == 0) && !txWin[i];
                if (req0[i]) begin
                    if (expAck0[i]) begin
                        if ($urandom_range(0, 1) == 1) begin
                            we0[i] = 1'($urandom_range(0, 1));
                            addr0[i] = 8'($urandom()); wdata0[i] = 8'($urandom());
                        end else begin
                            req0[i] = 1'b0;
                        end
                    end else if (!granted && $urandom_range(0, 15) == 0) begin
                        req0[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    req0[i] = 1'b1; we0[i] = 1'($urandom_range(0, 1));
                    addr0[i] = 8'($urandom()); wdata0[i] = 8'($urandom());
                end

                granted = (age == 0) && txWin[i];
                if (req1[i]) begin
                    if (expAck1[i]) begin
                        if ($urandom_range(0, 1) == 1) begin
                            we1[i] = 1'($urandom_range(0, 1));
                            addr1[i] = 8'($urandom()); wdata1[i] = 8'($urandom());
                        end else begin
                            req1[i] = 1'b0;
                        end
                    end else if (!granted && $urandom_range(0, 15) == 0) begin
                        req1[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    req1[i] = 1'b1; we1[i] = 1'($urandom_range(0, 1));
                    addr1[i] = 8'($urandom()); wdata1[i] = 8'($urandom());
                end
            end
        end
        idleInputs();
        repeat (3) tick();
    endtask

    // Directed scenarios first, then randomized traffic, then the summary.
    initial begin
        vectors     = 0;
        miscompares = 0;
        preloadReq  = 1'b0;
        test_reset();
        test_single_read();
        test_write_read();
        test_rr_contention();
        test_fixed_contention();
        test_reset_mid_write();
        test_holdoff();
        test_random(2000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
